// File: rtl/led_seq_pkg.sv
// Purpose: shared register map and mode encodings for the LED sequencer.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package led_seq_pkg;

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_PATTERN = 2'd1;
  localparam logic [1:0] ADDR_PERIOD  = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_ROTL   = 2'd2,
    MODE_ROTR   = 2'd3
  } mode_t;

endpackage

// File: rtl/led_tick_gen.sv
// Purpose: prescaler plus step counter; pulses tick once every PRESCALE*(period+1) cycles.
// Latency: tick is combinational from the counter state; clr takes effect at the next edge.
// Backpressure: none, free-running.
// Ports: CLK/Reset clock and async reset, clr synchronous restart of both counters,
//        period strobes per step minus one, tick single-cycle step pulse.
module led_tick_gen #(
  parameter int PRESCALE = 100000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        clr,
  input  logic [15:0] period,
  output logic        tick
);

  // PRESCALE=1 still needs a 1-bit counter that simply stays at zero.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre;
  logic [15:0]   step;
  logic          strobe;

  assign strobe = (pre == PRE_LAST);
  assign tick   = strobe && (step == period);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      pre  <= '0;
      step <= '0;
    end else if (clr) begin
      pre  <= '0;
      step <= '0;
    end else if (strobe) begin
      pre  <= '0;
      step <= tick ? 16'd0 : step + 16'd1;
    end else begin
      pre  <= pre + PW'(1);
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// Purpose: MMIO-programmed static/blink/rotate sequencer driving the LED register.
// Latency: a CTRL/PATTERN write or an effect step shows on LedWE/LedWD one cycle after cur updates.
// Backpressure: none, the LED register accepts every pulse.
// Ports: CLK/Reset clock and async reset; BusWE/BusAddr/BusWD processor store path;
//        BusRD combinational readback; LedWE/LedWD registered update pulse and display value.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int          PRESCALE   = 100000,
  parameter logic [15:0] PERIOD_RST = 16'd499
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        BusWE,
  input  logic [1:0]  BusAddr,
  input  logic [31:0] BusWD,
  output logic [31:0] BusRD,
  output logic        LedWE,
  output logic [31:0] LedWD
);

  mode_t       mode;
  logic [15:0] pattern;
  logic [15:0] period;
  logic [15:0] cur;
  logic        phase;
  logic        pend;
  logic        clr;
  logic        tick;
  logic        unused_wd;

  // Only the low half of the write data is ever stored.
  assign unused_wd = ^BusWD[31:16];

  // STATUS is read-only, so a store there must not disturb the step timing.
  assign clr = BusWE && (BusAddr != ADDR_STATUS);

  led_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .CLK    (CLK),
    .Reset  (Reset),
    .clr    (clr),
    .period (period),
    .tick   (tick)
  );

  always_comb begin
    BusRD = 32'd0;
    case (BusAddr)
      ADDR_CTRL:    BusRD = {30'd0, mode};
      ADDR_PATTERN: BusRD = {16'd0, pattern};
      ADDR_PERIOD:  BusRD = {16'd0, period};
      default:      BusRD = {15'd0, phase, cur};
    endcase
  end

  // pend marks a cur update; the LED pair is driven from it one edge later.
  // A bus store takes priority over a coincident tick, which is discarded.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      mode    <= MODE_STATIC;
      pattern <= 16'd0;
      period  <= PERIOD_RST;
      cur     <= 16'd0;
      phase   <= 1'b0;
      pend    <= 1'b0;
      LedWE   <= 1'b0;
      LedWD   <= 32'd0;
    end else begin
      LedWE <= pend;
      LedWD <= {16'd0, cur};
      pend  <= 1'b0;
      if (BusWE) begin
        case (BusAddr)
          ADDR_CTRL: begin
            mode  <= mode_t'(BusWD[1:0]);
            cur   <= pattern;
            phase <= 1'b0;
            pend  <= 1'b1;
          end
          ADDR_PATTERN: begin
            pattern <= BusWD[15:0];
            cur     <= BusWD[15:0];
            phase   <= 1'b0;
            pend    <= 1'b1;
          end
          ADDR_PERIOD: period <= BusWD[15:0];
          default: ;
        endcase
      end else if (tick) begin
        unique case (mode)
          MODE_STATIC: ;
          MODE_BLINK: begin
            // Entering phase 1 blanks the display; returning to phase 0 restores it.
            phase <= ~phase;
            cur   <= phase ? pattern : 16'd0;
            pend  <= 1'b1;
          end
          MODE_ROTL: begin
            cur  <= {cur[14:0], cur[15]};
            pend <= 1'b1;
          end
          MODE_ROTR: begin
            cur  <= {cur[0], cur[15:1]};
            pend <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
module tb_led_sequencer;
  import led_seq_pkg::*;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        BusWE;
  logic [1:0]  BusAddr;
  logic [31:0] BusWD;
  logic [31:0] BusRD;
  logic        LedWE;
  logic [31:0] LedWD;

  led_sequencer #(.PRESCALE(4), .PERIOD_RST(16'd499)) dut (
    .CLK     (CLK),
    .Reset   (Reset),
    .BusWE   (BusWE),
    .BusAddr (BusAddr),
    .BusWD   (BusWD),
    .BusRD   (BusRD),
    .LedWE   (LedWE),
    .LedWD   (LedWD)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  int          pcyc[$];
  logic [31:0] pval[$];
  logic        pst[$];

  typedef struct {
    logic [1:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [31:0] rexp;
    logic        pulse;
    logic [31:0] wdexp;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; the store is taken at the following posedge and
  // the task returns at the negedge after it.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    BusWE   = 1'b1;
    BusAddr = a;
    BusWD   = d;
    @(negedge CLK);
    BusWE   = 1'b0;
    BusWD   = 32'd0;
  endtask

  // Records every LedWE pulse seen at the next n negedges (index 1..n).
  task automatic capture(input int n);
    pcyc.delete();
    pval.delete();
    pst.delete();
    for (int i = 1; i <= n; i++) begin
      @(negedge CLK);
      if (LedWE) begin
        pcyc.push_back(i);
        pval.push_back(LedWD);
        pst.push_back(BusRD[16]);
      end
    end
  endtask

  task automatic read_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    BusAddr = a;
    #1;
    chk(name, BusRD, exp);
  endtask

  initial begin
    logic [15:0] e;

    vecs[0] = '{ADDR_PATTERN, 32'hFFFF1234, ADDR_PATTERN, 32'h00001234, 1'b1, 32'h00001234};
    vecs[1] = '{ADDR_PERIOD,  32'hABCD0007, ADDR_PERIOD,  32'h00000007, 1'b0, 32'h0};
    vecs[2] = '{ADDR_CTRL,    32'hFFFFFFFC, ADDR_CTRL,    32'h00000000, 1'b1, 32'h00001234};
    vecs[3] = '{ADDR_STATUS,  32'hFFFFFFFF, ADDR_STATUS,  32'h00001234, 1'b0, 32'h0};
    vecs[4] = '{ADDR_PERIOD,  32'h000001F3, ADDR_PERIOD,  32'h000001F3, 1'b0, 32'h0};
    vecs[5] = '{ADDR_PATTERN, 32'h0000A5A5, ADDR_STATUS,  32'h0000A5A5, 1'b1, 32'h0000A5A5};

    Reset = 1'b1; BusWE = 1'b0; BusAddr = 2'd0; BusWD = 32'd0;
    repeat (3) @(negedge CLK);
    chk("rst_ledwe", {31'd0, LedWE}, 32'd0);
    chk("rst_ledwd", LedWD, 32'd0);
    Reset = 1'b0;

    // 1: idle after reset
    capture(100);
    chk("idle_pulses", pcyc.size(), 0);
    chk("idle_ledwd", LedWD, 32'd0);
    read_chk("idle_period", ADDR_PERIOD, 32'd499);
    read_chk("idle_ctrl", ADDR_CTRL, 32'd0);
    read_chk("idle_status", ADDR_STATUS, 32'd0);

    // 2: register access table in static mode
    for (int i = 0; i < 6; i++) begin
      bus_write(vecs[i].waddr, vecs[i].wdata);
      read_chk($sformatf("vec%0d_rd", i), vecs[i].raddr, vecs[i].rexp);
      @(negedge CLK);
      chk($sformatf("vec%0d_we", i), {31'd0, LedWE}, {31'd0, vecs[i].pulse});
      if (vecs[i].pulse) chk($sformatf("vec%0d_wd", i), LedWD, vecs[i].wdexp);
      @(negedge CLK);
      chk($sformatf("vec%0d_we_once", i), {31'd0, LedWE}, 32'd0);
    end
    capture(200);
    chk("static_quiet", pcyc.size(), 0);

    // 3: rotate left, PERIOD=1 -> one step every 8 cycles, wraps after 16
    bus_write(ADDR_PERIOD, 32'd1);
    bus_write(ADDR_PATTERN, 32'h0001);
    bus_write(ADDR_CTRL, 32'd2);
    capture(132);
    chk("rotl_count", pcyc.size(), 17);
    e = 16'h0001;
    for (int k = 0; k < 17 && k < pcyc.size(); k++) begin
      chk($sformatf("rotl_cyc%0d", k), pcyc[k], 1 + 8 * k);
      chk($sformatf("rotl_val%0d", k), pval[k], {16'd0, e});
      e = {e[14:0], e[15]};
    end

    // 4: blink, PERIOD=0 -> toggle every 4 cycles, STATUS phase follows
    bus_write(ADDR_PERIOD, 32'd0);
    bus_write(ADDR_PATTERN, 32'hFFFF);
    bus_write(ADDR_CTRL, 32'd1);
    BusAddr = ADDR_STATUS;
    capture(22);
    chk("blink_count", pcyc.size(), 6);
    for (int k = 0; k < 6 && k < pcyc.size(); k++) begin
      chk($sformatf("blink_cyc%0d", k), pcyc[k], 1 + 4 * k);
      chk($sformatf("blink_val%0d", k), pval[k], (k % 2 == 1) ? 32'h0 : 32'hFFFF);
      chk($sformatf("blink_phase%0d", k), {31'd0, pst[k]}, (k % 2 == 1) ? 32'd1 : 32'd0);
    end

    // 5: rotate right, PATTERN store coinciding with a tick
    bus_write(ADDR_PERIOD, 32'd1);
    bus_write(ADDR_PATTERN, 32'h8001);
    bus_write(ADDR_CTRL, 32'd3);
    capture(7);
    chk("rotr_first_count", pcyc.size(), 1);
    if (pval.size() > 0) chk("rotr_first_val", pval[0], 32'h8001);
    bus_write(ADDR_PATTERN, 32'h00F0);
    capture(9);
    chk("rotr_coll_count", pcyc.size(), 2);
    if (pcyc.size() == 2) begin
      chk("rotr_coll_cyc0", pcyc[0], 1);
      chk("rotr_coll_val0", pval[0], 32'h00F0);
      chk("rotr_coll_cyc1", pcyc[1], 9);
      chk("rotr_coll_val1", pval[1], 32'h0078);
    end
    capture(6);
    chk("rotr_gap", pcyc.size(), 0);
    bus_write(ADDR_STATUS, 32'hFFFFFFFF);
    capture(3);
    chk("status_drops_tick", pcyc.size(), 0);
    bus_write(ADDR_STATUS, 32'hFFFFFFFF);
    capture(8);
    chk("status_keeps_cnt", pcyc.size(), 1);
    if (pcyc.size() == 1) begin
      chk("status_keeps_cyc", pcyc[0], 5);
      chk("status_keeps_val", pval[0], 32'h003C);
    end

    // 6: asynchronous reset mid-blink with a pulse pending
    bus_write(ADDR_PERIOD, 32'd0);
    bus_write(ADDR_PATTERN, 32'hFFFF);
    bus_write(ADDR_CTRL, 32'd1);
    repeat (4) @(negedge CLK);
    chk("pre_rst_ledwd", LedWD, 32'h0000FFFF);
    BusAddr = ADDR_CTRL;
    Reset = 1'b1;
    #1;
    chk("async_ledwd", LedWD, 32'd0);
    chk("async_mode", BusRD, 32'd0);
    @(negedge CLK);
    Reset = 1'b0;
    chk("rst_cancels_pulse", {31'd0, LedWE}, 32'd0);
    bus_write(ADDR_STATUS, 32'hFFFFFFFF);
    read_chk("post_ctrl", ADDR_CTRL, 32'd0);
    read_chk("post_pattern", ADDR_PATTERN, 32'd0);
    read_chk("post_period", ADDR_PERIOD, 32'd499);
    read_chk("post_status", ADDR_STATUS, 32'd0);
    capture(20);
    chk("post_pulses", pcyc.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
